// File: rtl/sum_bcd_converter.sv
// Sequential double-dabble converter: turns the 17-bit adder result {CO,Sum}
// into six BCD digits plus a leading-zero blanking mask, one bit per clock.
module sum_bcd_converter (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic        CO,
  input  logic [15:0] Sum,
  output logic        Busy,
  output logic        Done,
  output logic [23:0] Bcd,
  output logic [5:0]  Blank
);

  localparam int unsigned NumDigits = 6;
  localparam int unsigned OpWidth   = 17;

  typedef enum logic [0:0] {StIdle, StConv} state_e;

  state_e                 state_q, state_d;
  logic [OpWidth-1:0]     bin_q, bin_d;
  logic [4*NumDigits-1:0] dig_q, dig_d;
  logic [4:0]             cnt_q, cnt_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [4*NumDigits-1:0] bcd_q, bcd_d;
  logic [NumDigits-1:0]   blank_q, blank_d;

  logic                   last_iter;
  logic [4*NumDigits-1:0] dig_adj;
  logic [4*NumDigits-1:0] dig_shift;
  logic [OpWidth-1:0]     bin_shift;
  logic [NumDigits-1:0]   dig_zero;
  logic [NumDigits-1:0]   blank_mask;

  // Counter reads 16 during the 17th and final iteration.
  assign last_iter = (cnt_q == 5'd16);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (Start) state_d = StConv;
      StConv:  if (last_iter) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // One double-dabble step on the working registers
  // ---------------------------------------------------------------------------
  always_comb begin
    dig_adj = dig_q;
    for (int i = 0; i < NumDigits; i++) begin
      if (dig_q[4*i +: 4] >= 4'd5) begin
        dig_adj[4*i +: 4] = dig_q[4*i +: 4] + 4'd3;
      end
    end
  end

  assign dig_shift = {dig_adj[4*NumDigits-2:0], bin_q[OpWidth-1]};
  assign bin_shift = {bin_q[OpWidth-2:0], 1'b0};

  always_comb begin
    for (int i = 0; i < NumDigits; i++) begin
      dig_zero[i] = (dig_shift[4*i +: 4] == 4'd0);
    end
  end

  // A digit is blanked only if it and every more significant digit are zero.
  assign blank_mask[5] = dig_zero[5];
  assign blank_mask[4] = &dig_zero[5:4];
  assign blank_mask[3] = &dig_zero[5:3];
  assign blank_mask[2] = &dig_zero[5:2];
  assign blank_mask[1] = &dig_zero[5:1];
  assign blank_mask[0] = 1'b0;

  // ---------------------------------------------------------------------------
  // Output / datapath next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    bin_d   = bin_q;
    dig_d   = dig_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    blank_d = blank_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (Start) begin
          bin_d = {CO, Sum};
          dig_d = '0;
          cnt_d = '0;
        end
      end
      StConv: begin
        bin_d = bin_shift;
        dig_d = dig_shift;
        cnt_d = cnt_q + 5'd1;
        if (last_iter) begin
          bcd_d   = dig_shift;
          blank_d = blank_mask;
          done_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign busy_d = (state_d == StConv);

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      bin_q   <= '0;
      dig_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= '0;
      blank_q <= 6'b111110;
    end else begin
      bin_q   <= bin_d;
      dig_q   <= dig_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bcd_q   <= bcd_d;
      blank_q <= blank_d;
    end
  end

  assign Busy  = busy_q;
  assign Done  = done_q;
  assign Bcd   = bcd_q;
  assign Blank = blank_q;

endmodule

// File: tb/tb_sum_bcd_converter.sv
// Directed self-checking bench for sum_bcd_converter: reset values, latency,
// several operand values, ignored Start, back-to-back runs and mid-run reset.
module tb_sum_bcd_converter;

  logic        Clk;
  logic        Reset;
  logic        Start;
  logic        CO;
  logic [15:0] Sum;
  logic        Busy;
  logic        Done;
  logic [23:0] Bcd;
  logic [5:0]  Blank;

  int n_cmp;
  int n_mis;

  sum_bcd_converter dut (
    .Clk   (Clk),
    .Reset (Reset),
    .Start (Start),
    .CO    (CO),
    .Sum   (Sum),
    .Busy  (Busy),
    .Done  (Done),
    .Bcd   (Bcd),
    .Blank (Blank)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_mis++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp_v);
    end
  endtask

  // Advance one rising edge; inputs change and outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Launch one conversion. At loop cycle 'inject' a second Start is raised and
  // the operand inverted, both of which must have no effect.
  task automatic run_conv(input logic co, input logic [15:0] sum, input int inject,
                          output int lat, output int busy_n);
    CO    = co;
    Sum   = sum;
    Start = 1'b1;
    tick();
    Start  = 1'b0;
    lat    = 0;
    busy_n = Busy ? 1 : 0;
    while (!Done && lat < 40) begin
      if (lat == inject) begin
        Start = 1'b1;
        Sum   = ~Sum;
        CO    = ~CO;
      end else begin
        Start = 1'b0;
      end
      tick();
      lat++;
      if (Busy && !Done) busy_n++;
    end
    Start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!Done && lat < 40);
  endtask

  initial begin
    int lat;
    int busy_n;
    int done_cnt;

    n_cmp = 0;
    n_mis = 0;
    Reset = 1'b0;
    Start = 1'b1;
    CO    = 1'b1;
    Sum   = 16'hFFFF;

    // Reset, with Start asserted alongside it
    tick();
    tick();
    check("rst_busy",  Busy,  1'b0);
    check("rst_done",  Done,  1'b0);
    check("rst_bcd",   Bcd,   24'h000000);
    check("rst_blank", Blank, 6'b111110);
    Start = 1'b0;
    Reset = 1'b1;
    tick();
    check("rst_start_ignored", Busy, 1'b0);

    // Zero operand
    run_conv(1'b0, 16'h0000, -1, lat, busy_n);
    check("zero_lat",   lat,    17);
    check("zero_busy",  busy_n, 17);
    check("zero_bcd",   Bcd,    24'h000000);
    check("zero_blank", Blank,  6'b111110);
    tick();
    check("zero_done_pulse", Done, 1'b0);
    check("zero_idle",       Busy, 1'b0);

    // Maximum operand
    run_conv(1'b1, 16'hFFFF, -1, lat, busy_n);
    check("max_lat",   lat,   17);
    check("max_bcd",   Bcd,   24'h131071);
    check("max_blank", Blank, 6'b000000);

    // 65535
    run_conv(1'b0, 16'hFFFF, -1, lat, busy_n);
    check("ffff_bcd",   Bcd,   24'h065535);
    check("ffff_blank", Blank, 6'b100000);

    // 1234 with a stray Start and operand change mid-conversion
    run_conv(1'b0, 16'h04D2, 4, lat, busy_n);
    check("1234_lat",   lat,    17);
    check("1234_busy",  busy_n, 17);
    check("1234_bcd",   Bcd,    24'h001234);
    check("1234_blank", Blank,  6'b110000);
    tick();
    check("1234_no_restart", Busy, 1'b0);

    // Results hold while idle and inputs wander
    CO  = 1'b1;
    Sum = 16'h5A5A;
    repeat (5) tick();
    check("hold_bcd",   Bcd,   24'h001234);
    check("hold_blank", Blank, 6'b110000);

    // Start held high: back-to-back conversions
    CO    = 1'b0;
    Sum   = 16'h0009;
    Start = 1'b1;
    tick();
    wait_done(lat);
    check("b2b_lat0",   lat,   17);
    check("b2b_bcd0",   Bcd,   24'h000009);
    check("b2b_blank0", Blank, 6'b111110);
    Sum = 16'h000A;
    wait_done(lat);
    check("b2b_period", lat,   18);
    check("b2b_bcd1",   Bcd,   24'h000010);
    check("b2b_blank1", Blank, 6'b111100);
    Start = 1'b0;
    tick();
    check("b2b_stop", Busy, 1'b0);

    // Reset landing on iteration 8 of a conversion
    CO    = 1'b0;
    Sum   = 16'h1234;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    repeat (7) tick();
    check("abort_busy_pre", Busy, 1'b1);
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
    check("abort_busy",  Busy,  1'b0);
    check("abort_done",  Done,  1'b0);
    check("abort_bcd",   Bcd,   24'h000000);
    check("abort_blank", Blank, 6'b111110);
    done_cnt = 0;
    repeat (25) begin
      tick();
      if (Done) done_cnt++;
    end
    check("abort_no_done", done_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/sum_bcd_converter.md
SUM_BCD_CONVERTER -- requirements
Module: sum_bcd_converter

Interface
REQ-001 Parameters: none; input width fixed at 17 bits ({CO,Sum}), output fixed at 6 BCD digits.
REQ-002 Clk  input  1  system clock; all state updates on rising edge.
REQ-003 Reset  input  1  synchronous, active-low reset.
REQ-004 Start  input  1  conversion request, sampled on rising edge of Clk.
REQ-005 CO  input  1  registered adder carry-out; bit 16 of operand.
REQ-006 Sum  input  16  registered adder sum; bits 15:0 of operand.
REQ-007 Busy  output  1  high while conversion is in progress.
REQ-008 Done  output  1  one-cycle pulse marking a new result on Bcd/Blank.
REQ-009 Bcd  output  24  result digits; digit i = Bcd[4i+3:4i], digit 0 least significant.
REQ-010 Blank  output  6  leading-zero mask; Blank[i]=1 means digit i is a leading zero.

Function
REQ-011 Operand SHALL be the unsigned 17-bit value {CO,Sum}, range 0..131071.
REQ-012 FSM SHALL have exactly two states: IDLE and CONV.
REQ-013 In IDLE, Start=1 at an edge SHALL capture {CO,Sum} into the shift register, clear the working digit register and the iteration counter, and enter CONV.
REQ-014 In CONV, each edge SHALL perform one double-dabble iteration:
  - add 3 to every working digit >= 5;
  - shift the combined digit/binary register left by one;
  - move the binary MSB into digit 0 LSB.
REQ-015 CONV SHALL last exactly 17 cycles (17 iterations); the counter SHALL be 5 bits and SHALL NOT wrap within a conversion.
REQ-016 At the edge performing iteration 17:
  - Bcd SHALL load the post-iteration digit value;
  - Blank SHALL load its mask;
  - Done SHALL go to 1;
  - FSM SHALL return to IDLE.
REQ-017 Latency: Start sampled at edge e0 -> Busy=1 for the cycles following e0 through e16 -> Bcd, Blank and Done valid after e17.
REQ-018 Busy SHALL equal (state==CONV) and be registered.
REQ-019 Done SHALL be 1 for exactly one cycle per completed conversion, otherwise 0.
REQ-020 Start while Busy=1 SHALL be ignored; the operand SHALL NOT be re-captured.
REQ-021 Start=1 in the cycle Done=1 (FSM already IDLE) SHALL be accepted, giving back-to-back conversions every 18 cycles.
REQ-022 Start held high continuously SHALL restart a conversion on each return to IDLE.
REQ-023 Bcd and Blank SHALL hold their last values between conversions; only REQ-016 and reset SHALL update them.
REQ-024 Blank[0] SHALL always be 0; for i=1..5, Blank[i]=1 iff digit i and every higher digit are 0.
REQ-025 Every BCD digit in Bcd SHALL be in 0..9; digit 5 SHALL be 0 or 1.
REQ-026 CO and Sum SHALL be sampled only at the capturing edge; later changes SHALL NOT affect the result.

Reset
REQ-027 Reset=0 at an edge SHALL set:
  - FSM to IDLE;
  - Busy=0, Done=0;
  - Bcd=24'h000000, Blank=6'b111110;
  - working registers and counter to 0.
REQ-028 Reset SHALL take priority over Start and over an in-progress conversion; an aborted conversion SHALL produce no Done pulse.
REQ-029 Start=1 in the same cycle as Reset=0 SHALL be ignored.

Verification
REQ-030 CO=0, Sum=16'h0000, Start pulse -> Busy high 17 cycles, Done pulse, Bcd=24'h000000, Blank=6'b111110.
REQ-031 CO=1, Sum=16'hFFFF -> Bcd=24'h131071, Blank=6'b000000, Done exactly 17 edges after the capturing edge.
REQ-032 CO=0, Sum=16'hFFFF -> Bcd=24'h065535, Blank=6'b100000.
REQ-033 CO=0, Sum=16'h04D2:
  - Bcd=24'h001234, Blank=6'b110000;
  - second Start at cycle 5 of Busy is ignored;
  - Sum changed mid-conversion does not alter the result.
REQ-034 Start held high with operands 16'h0009 then 16'h000A:
  - conversions run back-to-back, 18-cycle period;
  - results Bcd=24'h000009, then 24'h000010.
REQ-035 Reset=0 at iteration 8 of a conversion of 16'h1234 -> next cycle Busy=0, Done=0, Bcd=0, Blank=6'b111110; no Done pulse follows.
